// File: rtl/hog_feed_pkg.sv
// hog_feed_pkg: shared derivations, corner-skipping pixel index map and FSM encoding for hog_cell_feeder.
package hog_feed_pkg;
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] LAST = 1'b1;
    function automatic int pix_n(input int s);
        return s * s - 4;
    endfunction
    function automatic int row_w(input int pw, input int s);
        return pw * s;
    endfunction
    function automatic int in_w(input int pw, input int s);
        return pw * pix_n(s);
    endfunction
    // Raster index with the four corners removed; -1 marks a corner.
    function automatic int pix_idx(input int s, input int r, input int c);
        if ((r == 0 || r == s - 1) && (c == 0 || c == s - 1))
            return -1;
        return r * s + c - (r == 0 ? 1 : r == s - 1 ? 3 : 2);
    endfunction
endpackage

// File: rtl/hog_win_fifo.sv
// hog_win_fifo: DEPTH-entry first-word-fall-through window queue with cleared storage on async reset.
module hog_win_fifo #(
    parameter int W     = 768,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         nonempty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr, rd;
    assign full     = cnt == (AW+1)'(DEPTH);
    assign nonempty = cnt != '0;
    assign wr       = push && !full;
    assign rd       = pop && nonempty;
    assign rdata    = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/hog_cell_feeder.sv
// hog_cell_feeder: assembles 10x10 bordered windows row by row, strips corners and queues packed words for hog_fetch.
// Optional HOG_FEED_STAT_EN adds a pushed-window counter and a sticky underflow flag.
module hog_cell_feeder import hog_feed_pkg::*; #(
    parameter int PIX_W  = 8,
    parameter int CELL_S = 10,
    parameter int DEPTH  = 4,
    localparam int PIX_N = pix_n(CELL_S),
    localparam int IN_W  = in_w(PIX_W, CELL_S),
    localparam int ROW_W = row_w(PIX_W, CELL_S)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_row_ready,
    output logic             ready,
    input  logic             request,
    output logic [IN_W-1:0]  o_data
`ifdef HOG_FEED_STAT_EN
    ,
    output logic [15:0]      o_win_cnt,
    output logic             o_underflow
`endif
);
    localparam int RW = $clog2(CELL_S);
    logic [RW-1:0]   row_cnt;
    logic [0:0]      state;
    logic [IN_W-1:0] acc, acc_nxt;
    logic            full, beat, push;
    assign state       = row_cnt == RW'(CELL_S - 1) ? LAST : ACC;
    // Only the final row waits for FIFO space; earlier rows park in the accumulator.
    assign o_row_ready = state == ACC || !full;
    assign beat        = i_valid && o_row_ready;
    assign push        = beat && state == LAST;
    for (genvar r = 0; r < CELL_S; r++) begin : g_row
        for (genvar c = 0; c < CELL_S; c++) begin : g_col
            localparam int k = pix_idx(CELL_S, r, c);
            if (k >= 0) begin : g_pix
                assign acc_nxt[PIX_W*k +: PIX_W] = row_cnt == RW'(r) ? i_row[PIX_W*c +: PIX_W] : acc[PIX_W*k +: PIX_W];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            acc     <= '0;
        end else if (beat) begin
            acc     <= acc_nxt;
            row_cnt <= state == LAST ? '0 : row_cnt + 1'b1;
        end
    end
    hog_win_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (acc_nxt),
        .pop      (request),
        .rdata    (o_data),
        .full     (full),
        .nonempty (ready)
    );
`ifdef HOG_FEED_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_win_cnt   <= '0;
            o_underflow <= 1'b0;
        end else begin
            if (push) o_win_cnt <= o_win_cnt + 1'b1;
            if (request && !ready) o_underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hog_cell_feeder.sv
// tb_hog_cell_feeder: directed and gapped-stream scoreboard bench for hog_cell_feeder.
module tb_hog_cell_feeder;
    localparam int PIX_W = 8;
    localparam int CELL_S = 10;
    localparam int ROW_W = 80;
    localparam int IN_W = 768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0;
    logic [ROW_W-1:0] i_row = '0;
    logic o_row_ready, ready;
    logic request = 1'b0;
    logic [IN_W-1:0] o_data;
`ifdef HOG_FEED_STAT_EN
    logic [15:0] o_win_cnt;
    logic o_underflow;
`endif

    int checks = 0;
    int errors = 0;
    int n_win = 0;
    logic [IN_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    hog_cell_feeder #(.PIX_W(PIX_W), .CELL_S(CELL_S), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_row       (i_row),
        .o_row_ready (o_row_ready),
        .ready       (ready),
        .request     (request),
        .o_data      (o_data)
`ifdef HOG_FEED_STAT_EN
        ,
        .o_win_cnt   (o_win_cnt),
        .o_underflow (o_underflow)
`endif
    );

    function automatic logic [7:0] pix(int seed, int r, int c);
        return 8'(seed * 37 + r * 10 + c);
    endfunction

    function automatic logic [ROW_W-1:0] mk_row(int seed, int r);
        logic [ROW_W-1:0] row;
        for (int c = 0; c < CELL_S; c++) row[8*c +: 8] = pix(seed, r, c);
        return row;
    endfunction

    function automatic logic [IN_W-1:0] model_word(int seed);
        logic [IN_W-1:0] w;
        int k;
        w = '0;
        k = 0;
        for (int r = 0; r < CELL_S; r++)
            for (int c = 0; c < CELL_S; c++)
                if (!((r == 0 || r == CELL_S-1) && (c == 0 || c == CELL_S-1))) begin
                    w[8*k +: 8] = pix(seed, r, c);
                    k++;
                end
        return w;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Scoreboard monitor: a pop happens on the coming edge whenever request && ready.
    always @(negedge clk) begin
        if (!rst && request && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected no window", o_data[63:0]);
            end else begin
                logic [IN_W-1:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL pop_word: got low %h expected low %h", o_data[63:0], e[63:0]);
                end
            end
        end
    end

    task automatic send_row(input logic [ROW_W-1:0] row, output int stalls);
        logic ok;
        i_valid = 1'b1;
        i_row = row;
        stalls = 0;
        forever begin
            @(negedge clk);
            ok = o_row_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            stalls++;
            if (stalls > 200) begin
                chk("row_accept_timeout", stalls, 0);
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic send_rows(input int seed, input int r0, input int r1, input bit gaps, output int stalls);
        int st;
        stalls = 0;
        for (int r = r0; r <= r1; r++) begin
            if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
            send_row(mk_row(seed, r), st);
            stalls += st;
        end
        if (r1 == CELL_S-1) n_win++;
    endtask

    task automatic send_win(input int seed);
        int st;
        exp_q.push_back(model_word(seed));
        send_rows(seed, 0, CELL_S-1, 1'b0, st);
    endtask

    task automatic pop_one();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) chk("pop_wait_timeout", n, 0);
        else begin
            request = 1'b1;
            @(posedge clk);
            #1;
            request = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        n_win = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, popped, cyc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_row_ready", o_row_ready, 1);
        chk("reset_o_data_nonzero", longint'(o_data != '0), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp window: pixel(r,c) = r*10+c.
        exp_q.push_back(model_word(0));
        send_rows(0, 0, CELL_S-2, 1'b0, st);
        i_valid = 1'b1;
        i_row = mk_row(0, CELL_S-1);
        @(negedge clk);
        chk("ready_before_last_edge", ready, 0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("ready_after_last", ready, 1);
        chk("k0", o_data[8*0 +: 8], 1);
        chk("k7", o_data[8*7 +: 8], 8);
        chk("k8", o_data[8*8 +: 8], 10);
        chk("k87", o_data[8*87 +: 8], 89);
        chk("k88", o_data[8*88 +: 8], 91);
        chk("k95", o_data[8*95 +: 8], 98);
        pop_one();
        chk("ramp_drained", ready, 0);

        // Fill: four windows queue, the fifth stalls only on its last row.
        for (int w = 1; w <= 4; w++) send_win(w);
        exp_q.push_back(model_word(5));
        send_rows(5, 0, CELL_S-2, 1'b0, st);
        chk("w5_rows_0_8_stalls", st, 0);
        i_valid = 1'b1;
        i_row = mk_row(5, CELL_S-1);
        request = 1'b1;
        @(negedge clk);
        chk("full_row_ready", o_row_ready, 0);
        @(posedge clk);
        #1;
        request = 1'b0;
        @(negedge clk);
        chk("unstall_row_ready", o_row_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n_win++;
        repeat (4) pop_one();
        chk("fill_drained", ready, 0);
        chk("fill_queue_empty", exp_q.size(), 0);

        // Push and pop on the same edge at count=2.
        send_win(11);
        send_win(12);
        exp_q.push_back(model_word(13));
        send_rows(13, 0, CELL_S-2, 1'b0, st);
        i_valid = 1'b1;
        i_row = mk_row(13, CELL_S-1);
        request = 1'b1;
        @(negedge clk);
        chk("inter_row_ready", o_row_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        request = 1'b0;
        n_win++;
        pop_one();
        chk("inter_ready_after_1", ready, 1);
        pop_one();
        chk("inter_ready_after_2", ready, 0);

        // Asynchronous reset mid-window with two windows queued.
        send_win(21);
        send_win(22);
        send_rows(23, 0, 4, 1'b0, st);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_row_ready", o_row_ready, 1);
        chk("midrst_o_data_nonzero", longint'(o_data != '0), 0);
        do_reset();
        send_win(24);
        pop_one();
        chk("midrst_drained", ready, 0);

        // Requests while empty must not move the read pointer.
        do_reset();
        request = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        request = 1'b0;
        chk("under_ready", ready, 0);
`ifdef HOG_FEED_STAT_EN
        chk("under_flag", o_underflow, 1);
`endif
        send_win(31);
        send_win(32);
        send_win(33);
`ifdef HOG_FEED_STAT_EN
        chk("win_cnt_3", o_win_cnt, n_win);
        chk("under_sticky", o_underflow, 1);
`endif
        repeat (3) pop_one();
        chk("under_drained", ready, 0);

        // Gapped producer against a random consumer.
        popped = 0;
        cyc = 0;
        fork
            for (int w = 0; w < 20; w++) begin
                int s2;
                exp_q.push_back(model_word(100 + w));
                send_rows(100 + w, 0, CELL_S-1, 1'b1, s2);
            end
            begin
                while (popped < 20 && cyc < 5000) begin
                    request = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (request && ready) popped++;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                request = 1'b0;
            end
        join
        chk("rand_popped", popped, 20);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_ready", ready, 0);
`ifdef HOG_FEED_STAT_EN
        chk("rand_win_cnt", o_win_cnt, n_win);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
